// File: rtl/mem_arbiter.sv
// Arbitrates the 16x8 memory port between CPU reads, loader byte writes and a
// one-shot clear sweep; writes use a setup/strobe/hold sequence.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_adr,
    output logic              cpu_grant,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_adr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_value
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CPU    = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADR = '1;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_wadr;
    logic [ADDR_W-1:0] w_wadr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              r_sweep;
    logic              w_sweep_nxt;
    logic              r_clr_pend;
    logic              w_clr_pend_nxt;
    logic              r_mem_write;
    logic              r_cpu_grant;
    logic              r_ld_ack;

    // State and registered outputs, decoded from the next state so they never glitch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wadr      <= '0;
            r_wdata     <= '0;
            r_sweep     <= 1'b0;
            r_clr_pend  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cpu_grant <= 1'b0;
            r_ld_ack    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wadr      <= w_wadr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_sweep     <= w_sweep_nxt;
            r_clr_pend  <= w_clr_pend_nxt;
            r_mem_write <= (w_state_nxt == S_STROBE);
            r_cpu_grant <= (w_state_nxt == S_CPU);
            r_ld_ack    <= (w_state_nxt == S_HOLD) && !w_sweep_nxt;
        end
    end

    // Next-state: fixed priority clear > loader > CPU, no preemption
    always_comb begin
        w_state_nxt    = r_state;
        w_wadr_nxt     = r_wadr;
        w_wdata_nxt    = r_wdata;
        w_sweep_nxt    = r_sweep;
        w_clr_pend_nxt = r_clr_pend | clr_start;
        case (r_state)
            S_IDLE: begin
                if (r_clr_pend) begin
                    w_sweep_nxt = 1'b1;
                    w_wadr_nxt  = '0;
                    w_wdata_nxt = CLR_VALUE;
                    w_state_nxt = S_SETUP;
                end else if (clr_start) begin
                    // Clear request is being registered; grant nothing so it wins next cycle
                    w_state_nxt = S_IDLE;
                end else if (ld_req) begin
                    w_wadr_nxt  = ld_adr;
                    w_wdata_nxt = ld_data;
                    w_state_nxt = S_SETUP;
                end else if (cpu_req) begin
                    w_state_nxt = S_CPU;
                end
            end
            S_CPU: begin
                if (!cpu_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (r_sweep && (r_wadr != LAST_ADR)) begin
                    w_wadr_nxt  = r_wadr + ADDR_W'(1);
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                    if (r_sweep) begin
                        w_sweep_nxt    = 1'b0;
                        w_clr_pend_nxt = 1'b0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory address: CPU address passes straight through while granted
    always_comb begin
        mem_adr = '0;
        case (r_state)
            S_CPU:                     mem_adr = cpu_adr;
            S_SETUP, S_STROBE, S_HOLD: mem_adr = r_wadr;
            default:                   mem_adr = '0;
        endcase
    end

    assign cpu_data  = r_cpu_grant ? mem_value : '0;
    assign cpu_grant = r_cpu_grant;
    assign ld_ack    = r_ld_ack;
    assign clr_busy  = r_clr_pend;
    assign mem_write = r_mem_write;
    assign mem_din   = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and a random
// phase, all checked against a job/phase-level model with its own memory image.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req = 1'b0;
    logic [3:0] cpu_adr = 4'h0;
    logic       cpu_grant;
    logic [7:0] cpu_data;
    logic       ld_req = 1'b0;
    logic [3:0] ld_adr = 4'h0;
    logic [7:0] ld_data = 8'h00;
    logic       ld_ack;
    logic       clr_start = 1'b0;
    logic       clr_busy;
    logic       mem_write;
    logic [3:0] mem_adr;
    logic [7:0] mem_din;
    logic [7:0] mem_value;

    logic [7:0] tb_mem [16] = '{default: 8'h00};

    mem_arbiter #(.ADDR_W(4), .DATA_W(8), .CLR_VALUE(8'h00)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_adr(cpu_adr), .cpu_grant(cpu_grant), .cpu_data(cpu_data),
        .ld_req(ld_req), .ld_adr(ld_adr), .ld_data(ld_data), .ld_ack(ld_ack),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .mem_write(mem_write), .mem_adr(mem_adr), .mem_din(mem_din), .mem_value(mem_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) tb_mem[mem_adr] <= mem_din;
    assign mem_value = tb_mem[mem_adr];

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Model: who owns the port, and for a write job its phase (0 setup, 1 strobe, 2 hold)
    int         m_owner = 0;
    int         m_phase = 0;
    bit         m_sweep = 1'b0;
    int         m_adr   = 0;
    logic [7:0] m_data  = 8'h00;
    bit         m_pend  = 1'b0;
    logic [7:0] m_mem [16] = '{default: 8'h00};

    logic       obs_grant, obs_write, obs_ack, obs_busy;
    logic [3:0] obs_adr;
    logic [7:0] obs_din, obs_cdata;
    bit         ld_auto = 1'b1;

    typedef struct {
        logic       cr; logic [3:0] ca;
        logic       lr; logic [3:0] la; logic [7:0] ld;
        logic       grant, wr, ack;
        logic [3:0] adr; logic [7:0] din, cdata;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual=%0h required=%0h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_phase = 0; m_sweep = 1'b0; m_adr = 0; m_data = 8'h00; m_pend = 1'b0;
    endtask

    task automatic model_step();
        bit start_req;
        start_req = clr_start && !m_pend;
        case (m_owner)
            0: begin
                if (m_pend) begin
                    m_owner = 2; m_phase = 0; m_sweep = 1'b1; m_adr = 0; m_data = 8'h00;
                end else if (clr_start) begin
                    m_owner = 0;
                end else if (ld_req) begin
                    m_owner = 2; m_phase = 0; m_sweep = 1'b0; m_adr = int'(ld_adr); m_data = ld_data;
                end else if (cpu_req) begin
                    m_owner = 1;
                end
            end
            1: if (!cpu_req) m_owner = 0;
            default: begin
                if (m_phase == 1) m_mem[m_adr] = m_data;
                if (m_phase < 2) m_phase++;
                else if (m_sweep && m_adr < 15) begin
                    m_adr++; m_phase = 0;
                end else begin
                    if (m_sweep) begin m_sweep = 1'b0; m_pend = 1'b0; end
                    m_owner = 0;
                end
            end
        endcase
        if (start_req) m_pend = 1'b1;
    endtask

    task automatic check_model();
        logic [3:0] e_adr;
        logic [7:0] e_cdata;
        e_adr   = (m_owner == 1) ? cpu_adr : (m_owner == 2) ? 4'(m_adr) : 4'h0;
        e_cdata = (m_owner == 1) ? m_mem[cpu_adr] : 8'h00;
        chk("cpu_grant", 32'(cpu_grant), 32'(m_owner == 1));
        chk("mem_write", 32'(mem_write), 32'(m_owner == 2 && m_phase == 1));
        chk("ld_ack",    32'(ld_ack),    32'(m_owner == 2 && m_phase == 2 && !m_sweep));
        chk("clr_busy",  32'(clr_busy),  32'(m_pend));
        chk("mem_adr",   32'(mem_adr),   32'(e_adr));
        chk("mem_din",   32'(mem_din),   32'(m_data));
        chk("cpu_data",  32'(cpu_data),  32'(e_cdata));
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
        obs_grant = cpu_grant; obs_write = mem_write; obs_ack = ld_ack; obs_busy = clr_busy;
        obs_adr = mem_adr; obs_din = mem_din; obs_cdata = cpu_data;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        cyc_n++;
        #1;
        if (ld_auto && obs_ack) ld_req = 1'b0;
    endtask

    task automatic run_until_ack(input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            sample();
            got = obs_ack;
            advance();
        end
        chk("ack_within_budget", 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, strobes, first_grant;
        bit order_ok, done, ack_seen;

        tbl[0] = '{1'b0, 4'd0, 1'b1, 4'd4, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 4'd0, 1'b1, 4'd7, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd4, 8'hA5, 8'h00};
        tbl[2] = '{1'b0, 4'd0, 1'b1, 4'd7, 8'h3C, 1'b0, 1'b1, 1'b0, 4'd4, 8'hA5, 8'h00};
        tbl[3] = '{1'b0, 4'd0, 1'b1, 4'd7, 8'h3C, 1'b0, 1'b0, 1'b1, 4'd4, 8'hA5, 8'h00};
        tbl[4] = '{1'b1, 4'd4, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 8'h00};
        tbl[5] = '{1'b1, 4'd4, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4, 8'hA5, 8'hA5};
        tbl[6] = '{1'b1, 4'd2, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2, 8'hA5, 8'h00};
        tbl[7] = '{1'b0, 4'd4, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4, 8'hA5, 8'hA5};
        tbl[8] = '{1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 8'h00};

        // Reset state
        reset = 1'b1;
        #12;
        chk("rst_grant", 32'(cpu_grant), 0); chk("rst_write", 32'(mem_write), 0);
        chk("rst_ack", 32'(ld_ack), 0);      chk("rst_busy", 32'(clr_busy), 0);
        chk("rst_adr", 32'(mem_adr), 0);     chk("rst_din", 32'(mem_din), 0);
        chk("rst_cdata", 32'(cpu_data), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // Vector table: loader write to 4, then CPU reads back
        ld_auto = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cpu_req = tbl[i].cr; cpu_adr = tbl[i].ca;
            ld_req = tbl[i].lr; ld_adr = tbl[i].la; ld_data = tbl[i].ld;
            sample();
            chk("tbl_grant", 32'(obs_grant), 32'(tbl[i].grant));
            chk("tbl_write", 32'(obs_write), 32'(tbl[i].wr));
            chk("tbl_ack",   32'(obs_ack),   32'(tbl[i].ack));
            chk("tbl_adr",   32'(obs_adr),   32'(tbl[i].adr));
            chk("tbl_din",   32'(obs_din),   32'(tbl[i].din));
            chk("tbl_cdata", 32'(obs_cdata), 32'(tbl[i].cdata));
            advance();
        end
        ld_auto = 1'b1;

        // Reset during the strobe of a loader write to address 3
        ld_req = 1'b1; ld_adr = 4'd3; ld_data = 8'h5A;
        sample(); advance();
        sample(); advance();
        sample();
        chk("pre_reset_strobe", 32'(mem_write), 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_write", 32'(mem_write), 0); chk("mid_rst_ack", 32'(ld_ack), 0);
        chk("mid_rst_adr", 32'(mem_adr), 0);     chk("mid_rst_din", 32'(mem_din), 0);
        chk("mid_rst_grant", 32'(cpu_grant), 0); chk("mid_rst_busy", 32'(clr_busy), 0);
        @(posedge clk); #1;
        ld_req = 1'b0; reset = 1'b0;
        model_reset();
        chk("adr3_untouched", 32'(tb_mem[3]), 32'(m_mem[3]));

        // CPU holds the port while the loader waits
        cpu_req = 1'b1; cpu_adr = 4'd0;
        sample(); advance();
        for (int a = 0; a < 3; a++) begin
            cpu_adr = 4'(a);
            if (a == 1) begin ld_req = 1'b1; ld_adr = 4'd9; ld_data = 8'h0F; end
            sample();
            chk("cpu_hold_grant", 32'(obs_grant), 1);
            chk("cpu_hold_nowrite", 32'(obs_write), 0);
            advance();
        end
        cpu_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("ld_after_cpu_write", 32'(obs_write), 32'(k == 3));
            advance();
        end
        run_until_ack(5);
        sample(); advance();

        // Clear sweep over preloaded memory
        clr_start = 1'b1;
        sample(); advance();
        clr_start = 1'b0;
        busy_cnt = 0; strobes = 0; order_ok = 1'b1; done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            sample();
            if (obs_busy) busy_cnt++;
            if (obs_write) begin
                if (obs_adr != 4'(strobes) || obs_din != 8'h00) order_ok = 1'b0;
                strobes++;
            end
            if (!obs_busy) done = 1'b1;
            advance();
        end
        chk("clr_done", 32'(done), 1);
        chk("clr_busy_cycles", 32'(busy_cnt), 49);
        chk("clr_strobes", 32'(strobes), 16);
        chk("clr_order", 32'(order_ok), 1);
        cpu_req = 1'b1; cpu_adr = 4'd0;
        sample(); advance();
        for (int a = 0; a < 16; a++) begin
            cpu_adr = 4'(a);
            sample();
            chk("clr_read_grant", 32'(obs_grant), 1);
            chk("clr_read_data", 32'(obs_cdata), 0);
            advance();
        end
        cpu_req = 1'b0;
        sample(); advance();
        sample(); advance();

        // Clear, loader and CPU requested together; second clear during the sweep
        clr_start = 1'b1; ld_req = 1'b1; ld_adr = 4'd6; ld_data = 8'h77;
        cpu_req = 1'b1; cpu_adr = 4'd6;
        sample(); advance();
        busy_cnt = 0; strobes = 0; order_ok = 1'b1; first_grant = -1; ack_seen = 1'b0;
        for (int k = 0; k < 150 && first_grant < 0; k++) begin
            clr_start = (k == 10);
            sample();
            if (obs_busy) busy_cnt++;
            if (obs_ack) begin
                ack_seen = 1'b1;
                chk("simul_ack_after_sweep", 32'(strobes), 17);
            end
            if (obs_write) begin
                if (strobes < 16 && (obs_adr != 4'(strobes) || obs_din != 8'h00)) order_ok = 1'b0;
                if (strobes == 16 && (obs_adr != 4'd6 || obs_din != 8'h77)) order_ok = 1'b0;
                strobes++;
            end
            if (obs_grant) begin
                first_grant = k;
                chk("simul_grant_after_ack", 32'(ack_seen), 1);
                chk("simul_cpu_data", 32'(obs_cdata), 32'h77);
            end
            advance();
        end
        clr_start = 1'b0;
        chk("simul_grant_seen", 32'(first_grant >= 0), 1);
        chk("simul_order", 32'(order_ok), 1);
        chk("simul_strobes", 32'(strobes), 17);
        chk("simul_busy_cycles", 32'(busy_cnt), 49);
        cpu_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("no_second_sweep", 32'(obs_busy), 0);
            advance();
        end

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) cpu_req = ~cpu_req;
            cpu_adr = 4'($urandom_range(0, 15));
            if (!ld_req && $urandom_range(0, 5) == 0) ld_req = 1'b1;
            ld_adr  = 4'($urandom_range(0, 15));
            ld_data = 8'($urandom_range(0, 255));
            clr_start = ($urandom_range(0, 79) == 0);
            sample(); advance();
        end
        cpu_req = 1'b0; clr_start = 1'b0;
        for (int k = 0; k < 60; k++) begin sample(); advance(); end
        for (int i = 0; i < 16; i++) chk("mem_image", 32'(tb_mem[i]), 32'(m_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
